// File: rtl/latch_bist_pkg.sv
// Shared types and step-table constants for the latch self-test engine.
package latch_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int          NUM_STEPS = 7;
  localparam int          NUM_TESTS = 6;
  localparam logic [2:0]  NO_FAIL   = 3'd7;
  localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

  // Bit i of each vector belongs to step i; STEP_EXP packs {Q,notQ} per step.
  localparam logic [6:0]  STEP_EN  = 7'b0010011;
  localparam logic [6:0]  STEP_D   = 7'b1001010;
  localparam logic [6:0]  STEP_CHK = 7'b1101111;
  localparam logic [13:0] STEP_EXP = {2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};

endpackage

// File: rtl/latch_bist_vec_rom.sv
// Combinational step table: step index -> latch drive, expected outputs, check flag.
module latch_bist_vec_rom
  import latch_bist_pkg::*;
(
  input  logic [2:0] idx,
  output logic       en,
  output logic       d,
  output logic [1:0] exp_qn,
  output logic       chk
);

  always_comb begin
    en     = 1'b0;
    d      = 1'b0;
    exp_qn = 2'b00;
    chk    = 1'b0;
    if (idx != NO_FAIL) begin
      en     = STEP_EN[idx];
      d      = STEP_D[idx];
      exp_qn = STEP_EXP[{idx, 1'b0} +: 2];
      chk    = STEP_CHK[idx];
    end
  end

endmodule

// File: rtl/latch_bist.sv
// Self-test engine for a level-sensitive D latch: applies the step table,
// waits SETTLE_CYCLES, checks {Q,notQ}. LATCH_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module latch_bist
  import latch_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  output logic       En,
  output logic       D,
  input  logic       Q,
  input  logic       notQ,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Passed,
  output logic       AllPassed,
  output logic [2:0] FailIdx
);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic       rom_en, rom_d, rom_chk;
  logic [1:0] rom_exp;
  logic       match, fail;

  latch_bist_vec_rom u_rom (
    .idx    (idx),
    .en     (rom_en),
    .d      (rom_d),
    .exp_qn (rom_exp),
    .chk    (rom_chk)
  );

  // Complementary outputs that agree are never a valid latch state.
  assign match = (Q != notQ) && ({Q, notQ} == rom_exp);
  assign fail  = rom_chk && !match;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (Start) state_nxt = S_APPLY;
      S_APPLY:        state_nxt = S_SETTLE;
      S_SETTLE:       if (cnt == 8'd0) state_nxt = S_CHECK;
      S_CHECK: begin
        if (idx == LAST_STEP) state_nxt = S_DONE;
`ifdef LATCH_BIST_STOP_ON_FAIL_EN
        else if (fail)        state_nxt = S_DONE;
`endif
        else                  state_nxt = S_APPLY;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      En      <= 1'b0;
      D       <= 1'b0;
      Passed  <= 8'd0;
      FailIdx <= NO_FAIL;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            idx     <= 3'd0;
            Passed  <= 8'd0;
            FailIdx <= NO_FAIL;
          end
        end
        S_APPLY: begin
          En <= rom_en;
          D  <= rom_d;
        end
        S_CHECK: begin
          if (rom_chk && match) Passed <= Passed + 8'd1;
          if (fail && FailIdx == NO_FAIL) FailIdx <= idx;
          if (state_nxt == S_APPLY) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Settle counter is pure datapath; its value only matters inside SETTLE.
  always_ff @(posedge Clk) begin
    if (state == S_APPLY)                        cnt <= 8'(SETTLE_CYCLES - 1);
    else if (state == S_SETTLE && cnt != 8'd0)   cnt <= cnt - 8'd1;
  end

  assign Busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign Done      = (state == S_DONE);
  assign AllPassed = Done && (Passed == 8'(NUM_TESTS));

endmodule

// File: tb/tb_latch_bist.sv
// Bench for latch_bist: emulates good and faulty latches and scores each run against a step-table model.
module tb_latch_bist;

  localparam int S   = 10;
  localparam int STP = S + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       en, d, q, nq;
  logic       busy, done, all_passed;
  logic [7:0] passed;
  logic [2:0] fail_idx;

  int checks = 0;
  int errors = 0;

  // Environment: latch personality and per-step random responses.
  int   mode = 0;
  int   cyc  = 0;
  logic lstate = 1'b0;
  int   resp[7];

  int t_en [7] = '{1, 1, 0, 0, 1, 0, 0};
  int t_d  [7] = '{0, 1, 0, 1, 0, 0, 1};
  int t_exp[7] = '{1, 2, 2, 2, 0, 1, 1};
  int t_chk[7] = '{1, 1, 1, 1, 0, 1, 1};

  latch_bist #(.SETTLE_CYCLES(S)) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Start     (start),
    .En        (en),
    .D         (d),
    .Q         (q),
    .notQ      (nq),
    .Busy      (busy),
    .Done      (done),
    .Passed    (passed),
    .AllPassed (all_passed),
    .FailIdx   (fail_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int st;
    if (en === 1'b1) lstate = d;
    case (mode)
      0: begin q = lstate; nq = ~lstate; end
      1: begin q = 1'b0;   nq = 1'b1;    end
      2: begin q = d;      nq = ~d;      end
      default: begin
        st = cyc / STP;
        if (st > 6) st = 6;
        {q, nq} = 2'(resp[st]);
      end
    endcase
  end

  // Reference: walk the step table with the chosen latch behaviour.
  task automatic model(input int m, output int ep, output int efi, output int es);
    int lq, r;
    bit stop;
    lq = 0; ep = 0; efi = 7; es = 0; stop = 0;
    for (int s = 0; s < 7; s++) begin
      if (!stop) begin
        es = s + 1;
        if (t_en[s] == 1) lq = t_d[s];
        case (m)
          0:       r = lq ? 2 : 1;
          1:       r = 1;
          2:       r = t_d[s] ? 2 : 1;
          default: r = resp[s];
        endcase
        if (t_chk[s] == 1) begin
          if (r == t_exp[s]) ep++;
          else begin
            if (efi == 7) efi = s;
`ifdef LATCH_BIST_STOP_ON_FAIL_EN
            stop = 1;
`endif
          end
        end
      end
    end
  endtask

  task automatic run(input int m, input int rp, input string name);
    int ep, efi, es, cycles;
    bit seen;
    mode = m;
    model(m, ep, efi, es);
    @(negedge clk); start = 1'b1; cyc = 0;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_start got %b want 1", name, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_at_start got %b want 0", name, done); end
    checks++; if (passed !== 8'd0) begin errors++; $display("FAIL %s passed_at_start got %0d want 0", name, passed); end
    checks++; if (fail_idx !== 3'd7) begin errors++; $display("FAIL %s failidx_at_start got %0d want 7", name, fail_idx); end
    seen = 0; cycles = 0;
    while (cycles < 200 && !seen) begin
      @(posedge clk); cyc++; cycles++; #1;
      if (done === 1'b1) seen = 1;
      start = (cycles == rp) && !seen;
      if (cycles == 20 && es * STP > 20) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_mid got %b want 1", name, busy); end
      end
    end
    start = 1'b0;
    checks++; if (!seen || cycles != es * STP) begin errors++; $display("FAIL %s done_latency got %0d want %0d", name, cycles, es * STP); end
    checks++; if (passed !== 8'(ep)) begin errors++; $display("FAIL %s passed got %0d want %0d", name, passed, ep); end
    checks++; if (fail_idx !== 3'(efi)) begin errors++; $display("FAIL %s failidx got %0d want %0d", name, fail_idx, efi); end
    checks++; if (all_passed !== (ep == 6)) begin errors++; $display("FAIL %s allpassed got %b want %b", name, all_passed, ep == 6); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %b want 0", name, busy); end
    checks++; if ({en, d} !== {1'(t_en[es-1]), 1'(t_d[es-1])}) begin
      errors++; $display("FAIL %s drive_hold got %b%b want %0d%0d", name, en, d, t_en[es-1], t_d[es-1]);
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (done !== 1'b1 || passed !== 8'(ep)) begin errors++; $display("FAIL %s done_level got %b/%0d want 1/%0d", name, done, passed, ep); end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({en, d, busy, done} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b want 0000", {en, d, busy, done}); end
    checks++; if (passed !== 8'd0 || all_passed !== 1'b0) begin errors++; $display("FAIL reset_passed got %0d/%b want 0/0", passed, all_passed); end
    checks++; if (fail_idx !== 3'd7) begin errors++; $display("FAIL reset_failidx got %0d want 7", fail_idx); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_hold got %b%b want 00", busy, done); end
  endtask

  task automatic test_good();        run(0, -1, "good");        endtask
  task automatic test_stuck();       run(1, -1, "stuck0");      endtask
  task automatic test_transparent(); run(2, -1, "nohold");      endtask

  task automatic test_reset_midrun();
    mode = 0;
    @(negedge clk); start = 1'b1; cyc = 0;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) begin @(posedge clk); cyc++; end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({en, d, busy, done, all_passed} !== 5'b00000) begin errors++; $display("FAIL midrst_ctl got %b want 00000", {en, d, busy, done, all_passed}); end
    checks++; if (passed !== 8'd0 || fail_idx !== 3'd7) begin errors++; $display("FAIL midrst_score got %0d/%0d want 0/7", passed, fail_idx); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run(0, -1, "after_reset");
  endtask

  task automatic test_start_ignored(); run(0, 40, "start_busy"); endtask
  task automatic test_back_to_back(); run(0, -1, "rerun_a"); run(2, -1, "rerun_b"); endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 7; s++) resp[s] = int'($urandom_range(0, 3));
      if (k < 4) begin
        // Bias some runs towards mostly-correct responses so passes occur too.
        for (int s = 0; s < 7; s++) if ($urandom_range(0, 3) != 0) resp[s] = t_exp[s];
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run(3, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck();
    test_transparent();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
